// File: rtl/spi_burst_ram_pkg.sv
// Shared opcode constants and FSM state encoding for the SPI burst RAM slave.
package spi_burst_ram_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WRITE,
    READ_TURN,
    READ,
    DROP
  } state_e;

endpackage

// File: rtl/spi_burst_ram_slave_if.sv
// Serial-side signal bundle of the SPI burst RAM slave.
interface spi_burst_ram_slave_if;
  logic ss_n;
  logic mosi;
  logic miso;
  logic busy;
  logic op_err;

  modport master (output ss_n, output mosi, input miso, input busy, input op_err);
  modport slave  (input ss_n, input mosi, output miso, output busy, output op_err);
endinterface

// File: rtl/spi_burst_ram_mem.sv
// Single-port synchronous RAM with registered read data; write wins if both strobes are set.
module spi_burst_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: neither the array nor the read register is reset: contents must survive rst,
  // and a resettable array could not be mapped onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave giving burst read/write access to an on-chip RAM, one bit per clk edge.
// Frame: 2-bit opcode, ADDR_W-bit address, then an unbounded stream of DATA_W-bit words.
module spi_burst_ram_slave
  import spi_burst_ram_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 8,
  localparam int HDR_W  = 2 + ADDR_W
) (
  input logic                  clk,
  input logic                  rst,
  spi_burst_ram_slave_if.slave spi
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(HDR_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);

  state_e            state;
  logic              armed;
  logic [CNT_W-1:0]  hdr_cnt;
  logic [HDR_W-2:0]  hdr_sh;
  logic [DATA_W-2:0] wr_sh;
  logic [BIT_W-1:0]  bit_idx;
  logic [ADDR_W-1:0] addr_ptr;
  logic              op_err_q;

  logic [HDR_W-1:0]  hdr_full;
  logic [1:0]        hdr_op;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic              mem_re;

  assign hdr_full = {hdr_sh, spi.mosi};
  assign hdr_op   = hdr_full[HDR_W-1 -: 2];
  assign wr_word  = {wr_sh, spi.mosi};

  // Strobes are combinational so the access lands on the very edge that samples the bit.
  assign mem_we = !rst && !spi.ss_n && (state == WRITE) && (bit_idx == '0);
  assign mem_re = !rst && !spi.ss_n &&
                  ((state == READ_TURN) || ((state == READ) && (bit_idx == '0)));

  spi_burst_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_ptr),
    .wdata (wr_word),
    .rdata (rd_data)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      armed    <= 1'b0;
      hdr_cnt  <= '0;
      hdr_sh   <= '0;
      wr_sh    <= '0;
      bit_idx  <= '0;
      addr_ptr <= '0;
      op_err_q <= 1'b0;
    end else begin
      op_err_q <= 1'b0;
      if (spi.ss_n) begin
        armed <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // A select already low when reset lifts is not a frame start.
            if (armed) begin
              hdr_sh  <= hdr_full[HDR_W-2:0];
              hdr_cnt <= CNT_W'(1);
              state   <= HEADER;
            end
          end
          HEADER: begin
            if (hdr_cnt == HDR_LAST) begin
              addr_ptr <= hdr_full[ADDR_W-1:0];
              bit_idx  <= BIT_LAST;
              wr_sh    <= '0;
              case (hdr_op)
                OP_WRITE: state <= WRITE;
                OP_READ:  state <= READ_TURN;
                default: begin
                  state    <= DROP;
                  op_err_q <= 1'b1;
                end
              endcase
            end else begin
              hdr_sh  <= hdr_full[HDR_W-2:0];
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end
          WRITE: begin
            wr_sh <= wr_word[DATA_W-2:0];
            if (bit_idx == '0) begin
              bit_idx  <= BIT_LAST;
              addr_ptr <= addr_ptr + 1'b1;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end
          READ_TURN: begin
            addr_ptr <= addr_ptr + 1'b1;
            bit_idx  <= BIT_LAST;
            state    <= READ;
          end
          READ: begin
            // Fetching the next word as the last bit retires keeps the stream gap-free.
            if (bit_idx == '0) begin
              bit_idx  <= BIT_LAST;
              addr_ptr <= addr_ptr + 1'b1;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end
          DROP:    state <= DROP;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi.miso   = (state == READ) ? rd_data[bit_idx] : 1'b0;
  assign spi.busy   = (state != IDLE);
  assign spi.op_err = op_err_q;

endmodule

// File: tb/tb_spi_burst_ram_slave.sv
// Self-checking bench: default (8/8) and swept (16/4) slaves against an array model of the RAM.
module tb_spi_burst_ram_slave;

  logic clk = 1'b0;
  logic rst;

  spi_burst_ram_slave_if bus_a ();
  spi_burst_ram_slave_if bus_b ();

  spi_burst_ram_slave #(.DATA_W(8),  .ADDR_W(8)) dut_a (.clk(clk), .rst(rst), .spi(bus_a));
  spi_burst_ram_slave #(.DATA_W(16), .ADDR_W(4)) dut_b (.clk(clk), .rst(rst), .spi(bus_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_a [256];
  logic [15:0] model_b [16];

  logic        tx_q [$];
  logic        rx_q [$];
  logic        err_q [$];
  logic        busy_q [$];
  logic [15:0] wr_words [$];
  logic [15:0] rd_words [$];
  logic        miso_end, busy_end, err_end;

  function automatic int dw(input bit sel);
    return sel ? 16 : 8;
  endfunction

  function automatic int aw(input bit sel);
    return sel ? 4 : 8;
  endfunction

  function automatic int depth(input bit sel);
    return sel ? 16 : 256;
  endfunction

  function automatic logic [15:0] model_rd(input bit sel, input int a);
    if (sel) return model_b[a % 16];
    return model_a[a % 256];
  endfunction

  function automatic void model_wr(input bit sel, input int a, input logic [15:0] v);
    if (sel) model_b[a % 16] = v;
    else     model_a[a % 256] = {8'h00, v[7:0]};
  endfunction

  function automatic void push_val(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endfunction

  function automatic int count_ones(input int from_idx);
    int c = 0;
    for (int i = from_idx; i < err_q.size(); i++) if (err_q[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic drive(input bit sel, input logic ss, input logic m);
    if (sel) begin bus_b.ss_n = ss; bus_b.mosi = m; end
    else     begin bus_a.ss_n = ss; bus_a.mosi = m; end
  endtask

  task automatic sample(input bit sel);
    rx_q.push_back(sel ? bus_b.miso : bus_a.miso);
    err_q.push_back(sel ? bus_b.op_err : bus_a.op_err);
    busy_q.push_back(sel ? bus_b.busy : bus_a.busy);
  endtask

  // Called at a negedge; rx_q[k] holds outputs after edge k. Leaves ss_n high for one edge.
  task automatic run_frame(input bit sel);
    rx_q.delete(); err_q.delete(); busy_q.delete();
    drive(sel, 1'b0, tx_q[0]);
    for (int i = 1; i < tx_q.size(); i++) begin
      @(negedge clk);
      sample(sel);
      drive(sel, 1'b0, tx_q[i]);
    end
    @(negedge clk);
    sample(sel);
    drive(sel, 1'b1, 1'b0);
    @(negedge clk);
    miso_end = sel ? bus_b.miso   : bus_a.miso;
    busy_end = sel ? bus_b.busy   : bus_a.busy;
    err_end  = sel ? bus_b.op_err : bus_a.op_err;
  endtask

  task automatic check_idle_end(input string tag);
    n_checks++;
    if (busy_end !== 1'b0 || miso_end !== 1'b0 || err_end !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_idle: busy=%b miso=%b op_err=%b, expected 0/0/0", tag, busy_end, miso_end, err_end);
    end
  endtask

  task automatic do_write(input bit sel, input int addr, input logic [15:0] extra, input int n_extra,
                          input string tag);
    int errs;
    tx_q.delete();
    push_val(16'h0, 2);
    push_val(16'(addr), aw(sel));
    foreach (wr_words[j]) push_val(wr_words[j], dw(sel));
    push_val(extra, n_extra);
    run_frame(sel);
    foreach (wr_words[j]) model_wr(sel, addr + j, wr_words[j]);
    errs = count_ones(0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s write_op_err: %0d pulses, expected 0", tag, errs);
    end
    check_idle_end(tag);
  endtask

  task automatic do_read(input bit sel, input int addr, input int n, input string tag);
    int hdr, w, bad, errs;
    logic [15:0] word, exp;
    hdr = 2 + aw(sel);
    w   = dw(sel);
    tx_q.delete();
    push_val(16'h1, 2);
    push_val(16'(addr), hdr - 2);
    for (int i = 0; i < n * w; i++) tx_q.push_back(1'($urandom()));
    run_frame(sel);
    rd_words.delete();
    bad = 0;
    for (int k = 0; k < hdr; k++) if (rx_q[k] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s hdr_turn_miso: %0d non-zero bits, expected 0", tag, bad);
    end
    for (int j = 0; j < n; j++) begin
      word = '0;
      for (int b = 0; b < w; b++) word = {word[14:0], rx_q[hdr + j * w + b]};
      rd_words.push_back(word);
      exp = model_rd(sel, addr + j);
      n_checks++;
      if (word !== exp) begin
        n_fail++;
        $display("FAIL %s read_word[%0d] @%0h: got %h expected %h", tag, j, (addr + j) % depth(sel), word, exp);
      end
    end
    errs = count_ones(0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s read_op_err: %0d pulses, expected 0", tag, errs);
    end
    check_idle_end(tag);
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [15:0] exp);
    n_checks++;
    if (rd_words[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s word[%0d]: got %h expected %h", tag, idx, rd_words[idx], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_a.busy, bus_a.miso, bus_a.op_err, bus_b.busy, bus_b.miso, bus_b.op_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%b%b%b b=%b%b%b expected all 0", bus_a.busy, bus_a.miso,
               bus_a.op_err, bus_b.busy, bus_b.miso, bus_b.op_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold_idle cycle %0d: busy a=%b b=%b expected 0", i, bus_a.busy, bus_b.busy);
      end
    end
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_fill();
    wr_words.delete();
    for (int i = 0; i < 256; i++) wr_words.push_back(16'($urandom()));
    do_write(0, 0, 16'h0, 0, "fill_a_wr");
    wr_words.delete();
    for (int i = 0; i < 16; i++) wr_words.push_back(16'($urandom()));
    do_write(1, 9, 16'h0, 0, "fill_b_wr");
    do_read(0, $urandom_range(255, 0), 256, "fill_a_rd");
    do_read(1, 7, 16, "fill_b_rd");
  endtask

  task automatic test_write_read();
    wr_words = '{16'h00A5, 16'h003C};
    do_write(0, 'h10, 16'h0, 0, "wr_rd");
    do_read(0, 'h10, 2, "wr_rd");
    expect_word("wr_rd", 0, 16'h00A5);
    expect_word("wr_rd", 1, 16'h003C);
  endtask

  task automatic test_wrap();
    wr_words = '{16'h0011, 16'h0022};
    do_write(0, 'hFF, 16'h0, 0, "wrap");
    do_read(0, 'hFF, 2, "wrap");
    expect_word("wrap", 0, 16'h0011);
    expect_word("wrap", 1, 16'h0022);
    do_read(0, 'h00, 1, "wrap_zero");
    expect_word("wrap_zero", 0, 16'h0022);
  endtask

  task automatic test_reserved_op();
    int a, hdr, bad_busy, bad_miso;
    logic [1:0] ops [2] = '{2'b10, 2'b11};
    hdr = 10;
    foreach (ops[o]) begin
      a = $urandom_range(255, 0);
      tx_q.delete();
      push_val({14'h0, ops[o]}, 2);
      push_val(16'(a), 8);
      push_val(16'($urandom()), 12);
      run_frame(0);
      n_checks++;
      if (err_q[hdr - 1] !== 1'b1 || count_ones(0) != 1) begin
        n_fail++;
        $display("FAIL reserved_op_err op=%b: at k=HDR_W-1 %b, total %0d pulses, expected 1 and 1",
                 ops[o], err_q[hdr - 1], count_ones(0));
      end
      bad_busy = 0;
      bad_miso = 0;
      foreach (busy_q[k]) if (busy_q[k] !== 1'b1) bad_busy++;
      foreach (rx_q[k]) if (rx_q[k] !== 1'b0) bad_miso++;
      n_checks++;
      if (bad_busy != 0 || bad_miso != 0) begin
        n_fail++;
        $display("FAIL reserved_drop op=%b: %0d cycles not busy, %0d miso ones, expected 0 and 0",
                 ops[o], bad_busy, bad_miso);
      end
      check_idle_end("reserved_op");
      do_read(0, a, 3, "reserved_unchanged");
    end
  endtask

  task automatic test_short_frame();
    int a, errs;
    a = $urandom_range(255, 0);
    tx_q.delete();
    push_val(16'h2, 2);
    push_val(16'(a >> 1), 7);
    run_frame(0);
    errs = count_ones(0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL short_frame_op_err: %0d pulses, expected 0", errs);
    end
    check_idle_end("short_frame");
    tx_q.delete();
    push_val(16'h0, 2);
    push_val(16'(a), 5);
    run_frame(0);
    check_idle_end("short_write");
    do_read(0, a, 2, "short_unchanged");
  endtask

  task automatic test_partial_write();
    logic [15:0] old;
    old = model_rd(0, 'h21);
    wr_words = '{16'h0077};
    do_write(0, 'h20, 16'h000F, 4, "partial");
    do_read(0, 'h20, 2, "partial");
    expect_word("partial", 0, 16'h0077);
    expect_word("partial", 1, old);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] w0;
    w0 = 8'h5A;
    wr_words = '{16'h005A, 16'h00C3};
    do_write(0, 'h05, 16'h0, 0, "rst_rd");
    tx_q.delete();
    push_val(16'h1, 2);
    push_val(16'h05, 8);
    for (int i = 0; i < 8; i++) tx_q.push_back(1'($urandom()));
    for (int i = 0; i < 14; i++) begin
      drive(0, 1'b0, tx_q[i]);
      @(negedge clk);
    end
    n_checks++;
    if (bus_a.miso !== w0[4] || bus_a.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rd_before: miso=%b busy=%b expected %b 1", bus_a.miso, bus_a.busy, w0[4]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_a.miso !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.op_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd_after: miso=%b busy=%b op_err=%b expected 0 0 0", bus_a.miso, bus_a.busy,
               bus_a.op_err);
    end
    rst = 1'b0;
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    do_read(0, 'h05, 2, "rst_rd_again");
    expect_word("rst_rd_again", 0, 16'h005A);
    expect_word("rst_rd_again", 1, 16'h00C3);
  endtask

  task automatic test_param_sweep();
    wr_words = '{16'hBEEF, 16'h1234};
    do_write(1, 'hF, 16'h0, 0, "sweep");
    do_read(1, 'hF, 2, "sweep");
    expect_word("sweep", 0, 16'hBEEF);
    expect_word("sweep", 1, 16'h1234);
    do_read(1, 'h0, 1, "sweep_zero");
    expect_word("sweep_zero", 0, 16'h1234);
  endtask

  task automatic test_back_to_back();
    int a;
    for (int r = 0; r < 2; r++) begin
      a = $urandom_range(255, 0);
      wr_words.delete();
      for (int i = 0; i < 3; i++) wr_words.push_back(16'($urandom()));
      do_write(0, a, 16'h0, 0, "b2b");
      do_read(0, a, 3, "b2b");
    end
  endtask

  task automatic test_random();
    bit sel;
    int a, n;
    for (int it = 0; it < 30; it++) begin
      sel = 1'($urandom());
      a   = $urandom_range(depth(sel) - 1, 0);
      n   = $urandom_range(4, 1);
      if ($urandom_range(1, 0) == 0) begin
        wr_words.delete();
        for (int i = 0; i < n; i++) wr_words.push_back(16'($urandom()));
        do_write(sel, a, 16'($urandom()), $urandom_range(dw(sel) - 1, 0), "rand_wr");
      end else begin
        do_read(sel, a, n, "rand_rd");
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    @(negedge clk);
    test_reset();
    test_fill();
    test_write_read();
    test_wrap();
    test_reserved_op();
    test_short_frame();
    test_partial_write();
    test_reset_mid_read();
    test_param_sweep();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
